// File: rtl/clock_mode_sequencer_pkg.sv
// Shared definitions for the alarm clock sequencer: mode encoding, display codes,
// BCD limits and the BCD increment-with-wrap used by every time/alarm field.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_AHOUR = 3'd3,
        SET_AMIN  = 3'd4
    } mode_t;

    localparam logic [1:0] EDIT_NONE = 2'b00;
    localparam logic [1:0] EDIT_HOUR = 2'b01;
    localparam logic [1:0] EDIT_MIN  = 2'b10;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    localparam logic [7:0] ALARM_DEF_HOUR = 8'h07;
    localparam logic [7:0] ALARM_DEF_MIN  = 8'h00;

    // Two-digit BCD increment; wraps to 00 once the field limit is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] res;
        if (val == max_val)
            res = 8'h00;
        else if (val[3:0] == 4'd9)
            res = {val[7:4] + 4'd1, 4'd0};
        else
            res = {val[7:4], val[3:0] + 4'd1};
        return res;
    endfunction

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            RUN:       nxt = SET_HOUR;
            SET_HOUR:  nxt = SET_MIN;
            SET_MIN:   nxt = SET_AHOUR;
            SET_AHOUR: nxt = SET_AMIN;
            default:   nxt = RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/clock_mode_sequencer_if.sv
// Tick strobes, raw buttons and display/alarm outputs of the clock sequencer.
interface clock_mode_sequencer_if;
    logic        tick_1hz;
    logic        tick_1khz;
    logic [1:0]  buttonsInput;
    logic [15:0] big_bin;
    logic [1:0]  edit_field;
    logic        alarm_view;
    logic        alarm;

    modport master (
        output tick_1hz, tick_1khz, buttonsInput,
        input  big_bin, edit_field, alarm_view, alarm
    );

    modport slave (
        input  tick_1hz, tick_1khz, buttonsInput,
        output big_bin, edit_field, alarm_view, alarm
    );
endinterface

// File: rtl/clock_mode_sequencer_btn_debounce.sv
// One front-panel button: 2-FF synchronizer, tick-sampled debounce, press pulse
// on the accepted rising edge and optional hold-to-repeat.
module btn_debounce #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_MS       = 100,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1khz,
    input  logic btn_raw,
    output logic evt
);
    localparam int DCW = $clog2(DEBOUNCE_MS + 1);
    localparam int RCW = $clog2(REPEAT_DELAY_MS + 1);

    logic           meta_q, meta_d;
    logic           sync_q, sync_d;
    logic           level_q, level_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           evt_q, evt_d;

    always_comb begin
        meta_d  = btn_raw;
        sync_d  = meta_q;
        level_d = level_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        evt_d   = 1'b0;

        // A sample matching the accepted level restarts the count toward a change.
        if (tick_1khz) begin
            if (sync_q == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCW'(DEBOUNCE_MS - 1)) begin
                level_d = sync_q;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q + DCW'(1);
            end
        end

        if (level_d && !level_q) begin
            evt_d  = 1'b1;
            rcnt_d = REPEAT_EN ? RCW'(REPEAT_DELAY_MS) : '0;
        end else if (!level_d) begin
            rcnt_d = '0;
        end else if (REPEAT_EN && tick_1khz) begin
            if (rcnt_q == RCW'(1)) begin
                evt_d  = 1'b1;
                rcnt_d = RCW'(REPEAT_MS);
            end else begin
                rcnt_d = rcnt_q - RCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            evt_q   <= evt_d;
        end
    end

    assign evt = evt_q;
endmodule

// File: rtl/clock_mode_sequencer.sv
// Alarm clock mode sequencer: button handling, mode FSM, BCD time/alarm registers,
// alarm ring timer and the registered 4-digit display word.
//
//   state     | meaning
//   RUN       | clock running, alarm armed, display shows time
//   SET_HOUR  | time frozen, increment bumps time hour
//   SET_MIN   | time frozen, increment bumps time minute
//   SET_AHOUR | time running, display/increment on alarm hour
//   SET_AMIN  | time running, display/increment on alarm minute
module clock_mode_sequencer #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_MS       = 100,
    parameter int ALARM_SECS      = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_mode_sequencer_if.slave bus
);
    import clock_pkg::*;

    localparam int ACW = $clog2(ALARM_SECS + 1);

    mode_t          state_q, state_d;
    logic [7:0]     hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [7:0]     ahh_q, ahh_d, amm_q, amm_d;
    logic           alarm_q, alarm_d;
    logic [ACW-1:0] acnt_q, acnt_d;
    logic           match_pend_q, match_pend_d;
    logic [15:0]    big_bin_q, big_bin_d;
    logic [1:0]     edit_field_q, edit_field_d;
    logic           alarm_view_q, alarm_view_d;

    logic sel_evt, inc_evt, ack, frozen, alarm_set;

    btn_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS), .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
        .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b0)
    ) u_sel (
        .clk(clk), .rst(rst), .tick_1khz(bus.tick_1khz),
        .btn_raw(bus.buttonsInput[0]), .evt(sel_evt)
    );

    btn_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS), .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
        .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b1)
    ) u_inc (
        .clk(clk), .rst(rst), .tick_1khz(bus.tick_1khz),
        .btn_raw(bus.buttonsInput[1]), .evt(inc_evt)
    );

    always_comb begin
        state_d      = state_q;
        hh_d         = hh_q;
        mm_d         = mm_q;
        ss_d         = ss_q;
        ahh_d        = ahh_q;
        amm_d        = amm_q;
        alarm_d      = alarm_q;
        acnt_d       = acnt_q;
        match_pend_d = bus.tick_1hz && (state_q == RUN);

        ack       = alarm_q && (sel_evt || inc_evt);
        frozen    = (state_q == SET_HOUR) || (state_q == SET_MIN);
        alarm_set = (state_q == SET_AHOUR) || (state_q == SET_AMIN);

        if (bus.tick_1hz && !frozen) begin
            ss_d = bcd_inc(ss_q, SEC_MAX);
            if (ss_q == SEC_MAX) begin
                mm_d = bcd_inc(mm_q, MIN_MAX);
                if (mm_q == MIN_MAX)
                    hh_d = bcd_inc(hh_q, HOUR_MAX);
            end
        end

        // Select beats increment; an acknowledging press does nothing else.
        if (sel_evt && !ack) begin
            state_d = next_mode(state_q);
            if (state_d == SET_HOUR)
                ss_d = 8'h00;
        end else if (inc_evt && !ack) begin
            case (state_q)
                SET_HOUR:  hh_d  = bcd_inc(hh_q, HOUR_MAX);
                SET_MIN:   mm_d  = bcd_inc(mm_q, MIN_MAX);
                SET_AHOUR: ahh_d = bcd_inc(ahh_q, HOUR_MAX);
                SET_AMIN:  amm_d = bcd_inc(amm_q, MIN_MAX);
                default:   ;
            endcase
        end

        if (alarm_q && bus.tick_1hz) begin
            acnt_d = acnt_q - ACW'(1);
            if (acnt_q == ACW'(1))
                alarm_d = 1'b0;
        end

        // Match is checked the cycle after the tick, against the updated time.
        if (match_pend_q && (state_q == RUN) && (hh_q == ahh_q) && (mm_q == amm_q) && (ss_q == 8'h00)) begin
            alarm_d = 1'b1;
            acnt_d  = ACW'(ALARM_SECS);
        end

        if (ack || (state_d != RUN)) begin
            alarm_d = 1'b0;
            acnt_d  = '0;
        end

        big_bin_d    = alarm_set ? {ahh_q, amm_q} : {hh_q, mm_q};
        alarm_view_d = alarm_set;
        case (state_q)
            SET_HOUR, SET_AHOUR: edit_field_d = EDIT_HOUR;
            SET_MIN, SET_AMIN:   edit_field_d = EDIT_MIN;
            default:             edit_field_d = EDIT_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            hh_q         <= 8'h00;
            mm_q         <= 8'h00;
            ss_q         <= 8'h00;
            ahh_q        <= ALARM_DEF_HOUR;
            amm_q        <= ALARM_DEF_MIN;
            alarm_q      <= 1'b0;
            acnt_q       <= '0;
            match_pend_q <= 1'b0;
            big_bin_q    <= 16'h0000;
            edit_field_q <= EDIT_NONE;
            alarm_view_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hh_q         <= hh_d;
            mm_q         <= mm_d;
            ss_q         <= ss_d;
            ahh_q        <= ahh_d;
            amm_q        <= amm_d;
            alarm_q      <= alarm_d;
            acnt_q       <= acnt_d;
            match_pend_q <= match_pend_d;
            big_bin_q    <= big_bin_d;
            edit_field_q <= edit_field_d;
            alarm_view_q <= alarm_view_d;
        end
    end

    assign bus.big_bin    = big_bin_q;
    assign bus.edit_field = edit_field_q;
    assign bus.alarm_view = alarm_view_q;
    assign bus.alarm      = alarm_q;
endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Directed bench for clock_mode_sequencer: reset, debounce, set/rollover,
// auto-repeat, alarm ring/timeout/acknowledge and simultaneous presses.
module tb_clock_mode_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clock_mode_sequencer_if bus ();

    clock_mode_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time expired, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic khz_tick();
        @(posedge clk);
        #1 bus.tick_1khz = 1'b1;
        @(posedge clk);
        #1 bus.tick_1khz = 1'b0;
    endtask

    task automatic hz_tick();
        @(posedge clk);
        #1 bus.tick_1hz = 1'b1;
        @(posedge clk);
        #1 bus.tick_1hz = 1'b0;
    endtask

    task automatic release_all();
        bus.buttonsInput = 2'b00;
        clk_n(3);
        repeat (20) khz_tick();
        clk_n(3);
    endtask

    task automatic press(input int idx);
        bus.buttonsInput[idx] = 1'b1;
        clk_n(3);
        repeat (20) khz_tick();
        clk_n(3);
        release_all();
    endtask

    task automatic presses(input int idx, input int n);
        for (int i = 0; i < n; i++) press(idx);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_n(3);
        rst = 1'b0;
        clk_n(1);
        checks++; if (bus.big_bin !== 16'h0000) begin errors++; $display("FAIL reset_big_bin: got %h want %h", bus.big_bin, 16'h0000); end
        checks++; if (bus.edit_field !== 2'b00) begin errors++; $display("FAIL reset_edit: got %b want %b", bus.edit_field, 2'b00); end
        checks++; if (bus.alarm_view !== 1'b0) begin errors++; $display("FAIL reset_alarm_view: got %b want 0", bus.alarm_view); end
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", bus.alarm); end
        presses(0, 3);
        checks++; if (bus.big_bin !== 16'h0700) begin errors++; $display("FAIL ahour_default: got %h want %h", bus.big_bin, 16'h0700); end
        checks++; if (bus.alarm_view !== 1'b1) begin errors++; $display("FAIL ahour_view: got %b want 1", bus.alarm_view); end
        checks++; if (bus.edit_field !== 2'b01) begin errors++; $display("FAIL ahour_edit: got %b want %b", bus.edit_field, 2'b01); end
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0;
        clk_n(1);
        checks++; if (bus.big_bin !== 16'h0000 || bus.alarm_view !== 1'b0 || bus.edit_field !== 2'b00) begin
            errors++; $display("FAIL midop_reset: got big_bin=%h view=%b edit=%b want 0000/0/00", bus.big_bin, bus.alarm_view, bus.edit_field);
        end
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 5; i++) begin
            bus.buttonsInput[0] = 1'b1;
            clk_n(3);
            khz_tick();
            bus.buttonsInput[0] = 1'b0;
            clk_n(3);
            khz_tick();
        end
        bus.buttonsInput[0] = 1'b1;
        clk_n(3);
        repeat (19) khz_tick();
        clk_n(3);
        checks++; if (bus.edit_field !== 2'b00) begin errors++; $display("FAIL debounce_early: got edit %b want %b", bus.edit_field, 2'b00); end
        khz_tick();
        clk_n(4);
        checks++; if (bus.edit_field !== 2'b01) begin errors++; $display("FAIL debounce_accept: got edit %b want %b", bus.edit_field, 2'b01); end
        release_all();
        checks++; if (bus.edit_field !== 2'b01) begin errors++; $display("FAIL debounce_single: got edit %b want %b", bus.edit_field, 2'b01); end
    endtask

    task automatic test_set_rollover();
        presses(1, 23);
        checks++; if (bus.big_bin !== 16'h2300) begin errors++; $display("FAIL hour_23: got %h want %h", bus.big_bin, 16'h2300); end
        press(1);
        checks++; if (bus.big_bin !== 16'h0000) begin errors++; $display("FAIL hour_wrap: got %h want %h", bus.big_bin, 16'h0000); end
        presses(1, 23);
        press(0);
        checks++; if (bus.edit_field !== 2'b10) begin errors++; $display("FAIL setmin_edit: got %b want %b", bus.edit_field, 2'b10); end
        presses(1, 59);
        checks++; if (bus.big_bin !== 16'h2359) begin errors++; $display("FAIL min_59: got %h want %h", bus.big_bin, 16'h2359); end
        press(1);
        checks++; if (bus.big_bin !== 16'h2300) begin errors++; $display("FAIL min_wrap: got %h want %h", bus.big_bin, 16'h2300); end
        presses(1, 59);
        presses(0, 3);
        checks++; if (bus.edit_field !== 2'b00 || bus.big_bin !== 16'h2359) begin
            errors++; $display("FAIL run_2359: got edit=%b big_bin=%h want 00/2359", bus.edit_field, bus.big_bin);
        end
        repeat (59) hz_tick();
        clk_n(3);
        checks++; if (bus.big_bin !== 16'h2359) begin errors++; $display("FAIL before_midnight: got %h want %h", bus.big_bin, 16'h2359); end
        hz_tick();
        clk_n(3);
        checks++; if (bus.big_bin !== 16'h0000) begin errors++; $display("FAIL midnight_roll: got %h want %h", bus.big_bin, 16'h0000); end
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL no_alarm_midnight: got %b want 0", bus.alarm); end
    endtask

    task automatic test_auto_repeat();
        presses(0, 2);
        bus.buttonsInput[1] = 1'b1;
        clk_n(3);
        repeat (519) khz_tick();
        clk_n(3);
        checks++; if (bus.big_bin !== 16'h0001) begin errors++; $display("FAIL repeat_delay: got %h want %h", bus.big_bin, 16'h0001); end
        khz_tick();
        clk_n(3);
        checks++; if (bus.big_bin !== 16'h0002) begin errors++; $display("FAIL repeat_first: got %h want %h", bus.big_bin, 16'h0002); end
        repeat (480) khz_tick();
        release_all();
        checks++; if (bus.big_bin !== 16'h0006) begin errors++; $display("FAIL repeat_total: got %h want %h", bus.big_bin, 16'h0006); end
        presses(0, 3);
    endtask

    task automatic test_alarm_ring();
        rst = 1'b1;
        clk_n(2);
        rst = 1'b0;
        presses(0, 3);
        presses(1, 17);
        checks++; if (bus.big_bin !== 16'h0000 || bus.alarm_view !== 1'b1) begin
            errors++; $display("FAIL alarm_hour_set: got big_bin=%h view=%b want 0000/1", bus.big_bin, bus.alarm_view);
        end
        press(0);
        press(1);
        checks++; if (bus.big_bin !== 16'h0001) begin errors++; $display("FAIL alarm_min_set: got %h want %h", bus.big_bin, 16'h0001); end
        press(0);
        checks++; if (bus.big_bin !== 16'h0000 || bus.edit_field !== 2'b00) begin
            errors++; $display("FAIL alarm_run: got big_bin=%h edit=%b want 0000/00", bus.big_bin, bus.edit_field);
        end
        repeat (59) hz_tick();
        clk_n(2);
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL alarm_early: got %b want 0", bus.alarm); end
        hz_tick();
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL alarm_latency1: got %b want 0", bus.alarm); end
        clk_n(1);
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL alarm_ring: got %b want 1", bus.alarm); end
        checks++; if (bus.big_bin !== 16'h0001) begin errors++; $display("FAIL alarm_time: got %h want %h", bus.big_bin, 16'h0001); end
        repeat (59) hz_tick();
        clk_n(2);
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL alarm_hold: got %b want 1", bus.alarm); end
        hz_tick();
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL alarm_timeout: got %b want 0", bus.alarm); end
    endtask

    task automatic test_alarm_ack();
        clk_n(3);
        presses(0, 4);
        presses(1, 2);
        checks++; if (bus.big_bin !== 16'h0003) begin errors++; $display("FAIL ack_alarm_set: got %h want %h", bus.big_bin, 16'h0003); end
        press(0);
        repeat (60) hz_tick();
        clk_n(2);
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL ack_ring: got %b want 1", bus.alarm); end
        press(1);
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b want 0", bus.alarm); end
        checks++; if (bus.big_bin !== 16'h0003 || bus.edit_field !== 2'b00) begin
            errors++; $display("FAIL ack_consumed: got big_bin=%h edit=%b want 0003/00", bus.big_bin, bus.edit_field);
        end
    endtask

    task automatic test_simultaneous();
        press(0);
        checks++; if (bus.edit_field !== 2'b01) begin errors++; $display("FAIL simul_pre: got edit %b want %b", bus.edit_field, 2'b01); end
        bus.buttonsInput = 2'b11;
        clk_n(3);
        repeat (20) khz_tick();
        clk_n(3);
        release_all();
        checks++; if (bus.edit_field !== 2'b10) begin errors++; $display("FAIL simul_state: got edit %b want %b", bus.edit_field, 2'b10); end
        checks++; if (bus.big_bin !== 16'h0003) begin errors++; $display("FAIL simul_hour: got %h want %h", bus.big_bin, 16'h0003); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.tick_1khz = 1'b0;
        bus.buttonsInput = 2'b00;
        test_reset();
        test_debounce();
        test_set_rollover();
        test_auto_repeat();
        test_alarm_ring();
        test_alarm_ack();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
